// File: rtl/ntt_pkg.sv
// Shared NTT datapath parameters and stage state encoding.
// Used by the pairing buffer, butterfly and collector stages.
package ntt_pkg;

  localparam int N_DEF         = 17;
  localparam int Q_DEF         = 65537;
  localparam int DEPTH_DEF     = 8;
  localparam int LOG_DEPTH_DEF = 3;

  typedef enum logic {
    FILL = 1'b0,
    PAIR = 1'b1
  } state_t;

endpackage

// File: rtl/ntt_delay_ram.sv
// DEPTH x W delay register file for the SDF pairing stage.
// Synchronous write, asynchronous read, shared address, no reset.
module ntt_delay_ram #(
  parameter int W     = 17,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // store first-half samples of the block
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ntt_sdf_pair_buffer.sv
// Delay-feedback pairing stage feeding a radix-2 DIF butterfly.
// Buffers half a block, then emits (a[i], a[i+DEPTH], i) pairs.
module ntt_sdf_pair_buffer
  import ntt_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int Q         = Q_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int LOG_DEPTH = LOG_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_a0,
  output logic [N-1:0]         out_a1,
  output logic [LOG_DEPTH-1:0] out_tw,
  output logic                 out_last,
  output logic                 range_err
);

  localparam logic [N:0] QLIM = (N+1)'(Q);
  localparam logic [LOG_DEPTH-1:0] CMAX =
    LOG_DEPTH'(DEPTH - 1);

  state_t               state;
  state_t               state_nx;
  logic [LOG_DEPTH-1:0] cnt;
  logic [N-1:0]         rd_data;
  logic                 xfer;
  logic                 wr_en;
  logic                 load;
  logic                 wrap;

  assign xfer  = in_valid && in_ready;
  assign wrap  = cnt == CMAX;
  assign wr_en = xfer && (state == FILL);
  assign load  = xfer && (state == PAIR);

  ntt_delay_ram #(
    .W     (N),
    .DEPTH (DEPTH),
    .AW    (LOG_DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .addr  (cnt),
    .wdata (in_data),
    .rdata (rd_data)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nx;
  end

  // next state and input handshake
  always_comb begin
    state_nx = state;
    in_ready = 1'b1;
    unique case (state)
      FILL: begin
        if (xfer && wrap) state_nx = PAIR;
      end
      PAIR: begin
        in_ready = !out_valid || out_ready;
        if (xfer && wrap) state_nx = FILL;
      end
      default: state_nx = FILL;
    endcase
  end

  // sample counter, advances on every transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (xfer) cnt <= cnt + LOG_DEPTH'(1);
  end

  // pair register: load on PAIR transfer, clear valid on drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_a0    <= '0;
      out_a1    <= '0;
      out_tw    <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_a0    <= rd_data;
      out_a1    <= in_data;
      out_tw    <= cnt;
      out_last  <= wrap;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // sticky out-of-range flag on accepted samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) range_err <= 1'b0;
    else if (xfer && ({1'b0, in_data} >= QLIM))
      range_err <= 1'b1;
  end

endmodule

// File: tb/tb_ntt_sdf_pair_buffer.sv
// Self-checking bench for ntt_sdf_pair_buffer.
// Directed table, corner sequences and random traffic vs a block model.
module tb_ntt_sdf_pair_buffer;

  localparam int N     = 17;
  localparam int Q     = 65537;
  localparam int DEPTH = 8;
  localparam int LD    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_a0;
  logic [N-1:0]  out_a1;
  logic [LD-1:0] out_tw;
  logic          out_last;
  logic          range_err;

  ntt_sdf_pair_buffer #(
    .N(N), .Q(Q), .DEPTH(DEPTH), .LOG_DEPTH(LD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a0    (out_a0),
    .out_a1    (out_a1),
    .out_tw    (out_tw),
    .out_last  (out_last),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  // reference model: samples of the current block, pending pair
  int blk[$];
  bit m_v, m_last, m_err;
  int m_a0, m_a1, m_tw;
  int log_a0[$];
  int log_a1[$];
  bit acc;
  bit rdy_seen;

  typedef struct {
    bit v;
    int d;
    bit r;
    bit ev;
    int ea0;
    int ea1;
    int etw;
    bit elast;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic model_reset();
    blk.delete();
    m_v = 0; m_a0 = 0; m_a1 = 0; m_tw = 0;
    m_last = 0; m_err = 0;
  endtask

  task automatic step(bit v, int d, bit r);
    bit exp_rdy;
    bit load;
    in_valid  = v;
    in_data   = d[N-1:0];
    out_ready = r;
    #1;
    exp_rdy  = (blk.size() < DEPTH) || !m_v || r;
    rdy_seen = in_ready;
    chk("in_ready", in_ready, exp_rdy);
    @(posedge clk);
    acc  = v && exp_rdy;
    load = 0;
    if (m_v && r) begin
      log_a0.push_back(m_a0);
      log_a1.push_back(m_a1);
    end
    if (acc) begin
      if (d >= Q) m_err = 1;
      blk.push_back(d);
      if (blk.size() > DEPTH) begin
        int i;
        i = blk.size() - 1 - DEPTH;
        load   = 1;
        m_a0   = blk[i];
        m_a1   = d;
        m_tw   = i;
        m_last = (i == DEPTH - 1);
        if (blk.size() == 2 * DEPTH) blk.delete();
      end
    end
    if (load) m_v = 1;
    else if (r) m_v = 0;
    #1;
    chk("out_valid", out_valid, m_v);
    if (m_v) begin
      chk("out_a0", out_a0, m_a0);
      chk("out_a1", out_a1, m_a1);
      chk("out_tw", out_tw, m_tw);
      chk("out_last", out_last, m_last);
    end
    chk("range_err", range_err, m_err);
  endtask

  task automatic clear_log();
    log_a0.delete();
    log_a1.delete();
  endtask

  // drained pairs must be (base+16b+k, base+16b+k+8)
  task automatic chk_pairs(string nm, int base, int blocks);
    chk({nm, "_count"}, log_a0.size(), blocks * DEPTH);
    if (log_a0.size() == blocks * DEPTH) begin
      for (int b = 0; b < blocks; b++)
        for (int k = 0; k < DEPTH; k++) begin
          int e;
          e = base + 2 * DEPTH * b + k;
          chk({nm, "_a0"}, log_a0[b*DEPTH+k], e);
          chk({nm, "_a1"}, log_a1[b*DEPTH+k], e + DEPTH);
        end
    end
  endtask

  task automatic feed(int base, int cnt);
    for (int k = 0; k < cnt; k++) step(1, base + k, 1);
    step(0, 0, 1);
  endtask

  initial begin
    int idx, stall, guard;
    bit r;

    // continuous stream table: pair k visible after sample k+8
    for (int c = 0; c < 17; c++) begin
      tbl[c].v     = (c < 16);
      tbl[c].d     = (c < 16) ? c : 0;
      tbl[c].r     = 1;
      tbl[c].ev    = (c >= 8) && (c < 16);
      tbl[c].ea0   = c - 8;
      tbl[c].ea1   = c;
      tbl[c].etw   = c - 8;
      tbl[c].elast = (c == 15);
    end

    rst = 1; in_valid = 0; in_data = '0; out_ready = 0;
    model_reset();
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_a0", out_a0, 0);
    chk("rst_a1", out_a1, 0);
    chk("rst_tw", out_tw, 0);
    chk("rst_last", out_last, 0);
    chk("rst_err", range_err, 0);
    chk("rst_ready", in_ready, 1);
    @(negedge clk);
    rst = 0;

    clear_log();
    for (int c = 0; c < 17; c++) begin
      step(tbl[c].v, tbl[c].d, tbl[c].r);
      chk("tbl_valid", out_valid, tbl[c].ev);
      if (tbl[c].ev) begin
        chk("tbl_a0", out_a0, tbl[c].ea0);
        chk("tbl_a1", out_a1, tbl[c].ea1);
        chk("tbl_tw", out_tw, tbl[c].etw);
        chk("tbl_last", out_last, tbl[c].elast);
      end
    end
    chk_pairs("cont", 0, 1);

    // backpressure after pair (2,10)
    clear_log();
    idx = 0; stall = 0; guard = 0;
    while (idx < 16 && guard < 100) begin
      r = (stall == 0);
      if (stall > 0) stall--;
      step(1, idx, r);
      if (!r) begin
        chk("bp_ready", rdy_seen, 0);
        chk("bp_hold_a0", out_a0, 2);
        chk("bp_hold_a1", out_a1, 10);
      end
      if (acc) begin
        idx++;
        if (idx == 11) stall = 3;
      end
      guard++;
    end
    chk("bp_timeout", guard < 100, 1);
    step(0, 0, 1);
    chk_pairs("bp", 0, 1);

    // back-to-back blocks, stall on first FILL cycle of block 2
    clear_log();
    for (int k = 0; k < 32; k++) begin
      step(1, 100 + k, k != 16);
      if (k == 16) begin
        chk("b2b_fill_ready", rdy_seen, 1);
        chk("b2b_held_a0", out_a0, 107);
      end
    end
    step(0, 0, 1);
    chk_pairs("b2b", 100, 2);

    // sparse input
    clear_log();
    for (int c = 0; c < 32; c++) step(c % 2 == 0, c / 2, 1);
    step(0, 0, 1);
    chk_pairs("sparse", 0, 1);

    // range check on sample 3
    clear_log();
    for (int k = 0; k < 16; k++) begin
      step(1, (k == 3) ? 65537 : k, 1);
      if (k == 3) chk("rng_set", range_err, 1);
    end
    feed(16, 16);
    chk("rng_sticky", range_err, 1);
    chk("rng_cnt", log_a0.size(), 16);
    if (log_a0.size() == 16) begin
      chk("rng_pair_a0", log_a0[3], 65537);
      chk("rng_pair_a1", log_a1[3], 11);
      chk("rng_next_a0", log_a0[4], 4);
    end

    // reset mid-PAIR with a pending pair
    for (int k = 0; k < 11; k++) step(1, k, k < 10);
    chk("pre_rst_valid", out_valid, 1);
    rst = 1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_a0", out_a0, 0);
    chk("mid_rst_a1", out_a1, 0);
    chk("mid_rst_tw", out_tw, 0);
    chk("mid_rst_err", range_err, 0);
    model_reset();
    clear_log();
    @(negedge clk);
    rst = 0;
    feed(200, 16);
    chk_pairs("post_rst", 200, 1);

    // random traffic against the model
    for (int c = 0; c < 2000; c++) begin
      int d;
      d = ($urandom_range(0, 99) == 0)
          ? $urandom_range(Q, 131071)
          : $urandom_range(0, Q - 1);
      step($urandom_range(0, 9) < 7, d,
           $urandom_range(0, 9) < 7);
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
